// File: rtl/ldpc_phase_scheduler_pkg.sv
// ldpc_phase_scheduler_pkg: phase codes and default geometry shared by the decoder blocks
package ldpc_phase_scheduler_pkg;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_LOAD = 3'd1,
        PH_SYN  = 3'd2,
        PH_CN   = 3'd3,
        PH_VN   = 3'd4,
        PH_DONE = 3'd5
    } phase_e;

    localparam int N_DEF        = 12;
    localparam int M_DEF        = 6;
    localparam int MAX_ITER_DEF = 30;
    localparam int LAT_DEF      = 2;
    localparam int LOG2N_DEF    = 4;
    localparam int LOG2M_DEF    = 3;
    localparam int LOG2ITER_DEF = 5;

    function automatic int addr_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ldpc_phase_scheduler_if.sv
// ldpc_phase_scheduler_if: control and BRAM strobe bundle between decoder controller and scheduler
interface ldpc_phase_scheduler_if
    import ldpc_phase_scheduler_pkg::*;
#(
    parameter int AW = addr_width(LOG2N_DEF, LOG2M_DEF),
    parameter int IW = LOG2ITER_DEF
);
    logic          i_start;
    logic          i_abort;
    logic          i_syn_in;
    logic [2:0]    o_phase;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic          o_busy;
    logic          o_done;
    logic          o_success;
    logic [IW-1:0] o_iterations;

    modport master (
        output i_start, i_abort, i_syn_in,
        input  o_phase, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr,
        input  o_busy, o_done, o_success, o_iterations
    );

    modport slave (
        input  i_start, i_abort, i_syn_in,
        output o_phase, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr,
        output o_busy, o_done, o_success, o_iterations
    );
endinterface

// File: rtl/ldpc_phase_scheduler_sweep_counter.sv
// sweep_counter: walks node indices 0..K-1 and replays them LAT cycles later as write-backs
module sweep_counter #(
    parameter int AW  = 4,
    parameter int LAT = 2,
    parameter int CW  = AW + 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] i_k,
    input  logic          i_go,
    input  logic          i_clr,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic          o_last
);
    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic [LAT-1:0] r_en_dl;
    logic [AW-1:0] r_addr_dl [LAT];

    assign o_rd_en   = r_active && (r_cnt < i_k);
    assign o_rd_addr = o_rd_en ? r_cnt[AW-1:0] : '0;
    assign o_last    = r_active && (r_cnt == i_k + CW'(LAT - 1));
    assign o_wr_en   = r_en_dl[LAT-1];
    assign o_wr_addr = r_addr_dl[LAT-1];

    // sweep position; a go in the final cycle chains straight into the next sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (i_clr) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (i_go) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
        end else if (o_last) begin
            r_active <= 1'b0;
        end else if (r_active) begin
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // read strobe/address delay line; flushing it drops any pending write-backs
    always_ff @(posedge clk or posedge rst) begin
        if (rst || i_clr) begin
            r_en_dl <= '0;
            for (int i = 0; i < LAT; i++) r_addr_dl[i] <= '0;
        end else begin
            r_en_dl[0]   <= o_rd_en;
            r_addr_dl[0] <= o_rd_addr;
            for (int i = 1; i < LAT; i++) begin
                r_en_dl[i]   <= r_en_dl[i-1];
                r_addr_dl[i] <= r_addr_dl[i-1];
            end
        end
    end
endmodule

// File: rtl/ldpc_phase_scheduler.sv
// ldpc_phase_scheduler: sequences load, syndrome, check-node and variable-node sweeps of an LDPC decoder
module ldpc_phase_scheduler
    import ldpc_phase_scheduler_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int M        = M_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int LAT      = LAT_DEF,
    parameter int LOG2N    = LOG2N_DEF,
    parameter int LOG2M    = LOG2M_DEF,
    parameter int LOG2ITER = LOG2ITER_DEF
) (
    input logic clk,
    input logic rst,
    ldpc_phase_scheduler_if.slave bus
);
    localparam int AW = addr_width(LOG2N, LOG2M);
    localparam int CW = AW + 3;

    phase_e                r_state;
    phase_e                w_next;
    logic                  w_go;
    logic                  w_clr;
    logic                  w_chk;
    logic                  w_nz_now;
    logic [CW-1:0]         w_k;
    logic                  w_rd_en;
    logic [AW-1:0]         w_rd_addr;
    logic                  w_wr_en;
    logic [AW-1:0]         w_wr_addr;
    logic                  w_last;
    logic                  r_nz;
    logic                  r_success;
    logic [LOG2ITER-1:0]   r_iter;

    assign w_k      = (r_state == PH_LOAD || r_state == PH_VN) ? CW'(N) : CW'(M);
    assign w_chk    = (r_state == PH_SYN || r_state == PH_CN);
    assign w_nz_now = r_nz || (w_chk && w_wr_en && bus.i_syn_in);

    sweep_counter #(.AW(AW), .LAT(LAT), .CW(CW)) u_sweep (
        .clk       (clk),
        .rst       (rst),
        .i_k       (w_k),
        .i_go      (w_go),
        .i_clr     (w_clr),
        .o_rd_en   (w_rd_en),
        .o_rd_addr (w_rd_addr),
        .o_wr_en   (w_wr_en),
        .o_wr_addr (w_wr_addr),
        .o_last    (w_last)
    );

    // phase register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= PH_IDLE;
        else     r_state <= w_next;
    end

    // phase transitions; abort wins over any sweep-end decision
    always_comb begin
        w_next = r_state;
        w_go   = 1'b0;
        w_clr  = 1'b0;
        if (r_state != PH_IDLE && bus.i_abort) begin
            w_next = PH_IDLE;
            w_clr  = 1'b1;
        end else begin
            case (r_state)
                PH_IDLE: if (bus.i_start) begin
                    w_next = PH_LOAD;
                    w_go   = 1'b1;
                end
                PH_LOAD: if (w_last) begin
                    w_next = PH_SYN;
                    w_go   = 1'b1;
                end
                PH_SYN: if (w_last) begin
                    w_next = w_nz_now ? PH_CN : PH_DONE;
                    w_go   = w_nz_now;
                end
                PH_CN: if (w_last) begin
                    w_next = (!w_nz_now || r_iter == LOG2ITER'(MAX_ITER)) ? PH_DONE : PH_VN;
                    w_go   = (w_next == PH_VN);
                end
                PH_VN: if (w_last) begin
                    w_next = PH_CN;
                    w_go   = 1'b1;
                end
                PH_DONE: w_next = PH_IDLE;
                default: w_next = PH_IDLE;
            endcase
        end
    end

    // nonzero-syndrome flag, restarted with every sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              r_nz <= 1'b0;
        else if (w_go || w_clr)               r_nz <= 1'b0;
        else if (w_chk && w_wr_en && bus.i_syn_in) r_nz <= 1'b1;
    end

    // frame result and iteration count, held between frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_success <= 1'b0;
            r_iter    <= '0;
        end else if (r_state == PH_IDLE) begin
            if (bus.i_start) begin
                r_success <= 1'b0;
                r_iter    <= '0;
            end
        end else if (bus.i_abort) begin
            r_success <= 1'b0;
        end else begin
            if (r_state == PH_VN && w_last && r_iter != LOG2ITER'(MAX_ITER)) r_iter <= r_iter + LOG2ITER'(1);
            if (w_next == PH_DONE) r_success <= !w_nz_now;
        end
    end

    assign bus.o_phase      = r_state;
    assign bus.o_rd_en      = w_rd_en;
    assign bus.o_rd_addr    = w_rd_addr;
    assign bus.o_wr_en      = w_wr_en;
    assign bus.o_wr_addr    = w_wr_addr;
    assign bus.o_busy       = (r_state != PH_IDLE);
    assign bus.o_done       = (r_state == PH_DONE);
    assign bus.o_success    = r_success;
    assign bus.o_iterations = r_iter;
endmodule

// File: tb/tb_ldpc_phase_scheduler.sv
// tb_ldpc_phase_scheduler: cycle trace of whole frames against a sweep-level model of the schedule
module tb_ldpc_phase_scheduler;
    import ldpc_phase_scheduler_pkg::*;

    localparam int N   = 12;
    localparam int M   = 6;
    localparam int MI  = 30;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ldpc_phase_scheduler_if #(.AW(4), .IW(5)) bus ();

    ldpc_phase_scheduler #(
        .N(N), .M(M), .MAX_ITER(MI), .LAT(LAT), .LOG2N(4), .LOG2M(3), .LOG2ITER(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0] ph;
        logic       rd;
        logic [3:0] ra;
        logic       wr;
        logic [3:0] wa;
        logic       syn;
    } ent_t;

    ent_t q[$];
    bit   exp_succ;
    int   exp_iter;
    int   total = 0;
    int   bad   = 0;

    // one sweep of k nodes: reads 0..k-1, writes the same indices LAT cycles later
    function automatic void push_sweep(input int ph, input int k, input logic [15:0] bits);
        ent_t e;
        for (int c = 0; c < k + LAT; c++) begin
            e.ph  = 3'(ph);
            e.rd  = (c < k);
            e.ra  = (c < k) ? 4'(c) : 4'd0;
            e.wr  = (c >= LAT);
            e.wa  = (c >= LAT) ? 4'(c - LAT) : 4'd0;
            e.syn = 1'($urandom);
            if (c >= LAT) e.syn = bits[c-LAT];
            q.push_back(e);
        end
    endfunction

    function automatic logic pat(input int mode, input int s, input int i);
        if (mode == 0) return 1'b0;
        if (mode == 1) return (s == 0 && i == 3);
        if (mode == 2) return 1'b1;
        return ($urandom_range(0, 3) == 0);
    endfunction

    // expected frame: decisions are made per sweep from the OR of its parity bits
    function automatic void build(input int mode);
        ent_t       e;
        logic [15:0] b;
        int         ph;
        int         s;
        q.delete();
        exp_iter = 0;
        ph = 2;
        s  = 0;
        push_sweep(1, N, 16'($urandom));
        while (1) begin
            b = '0;
            for (int i = 0; i < M; i++) b[i] = pat(mode, s, i);
            push_sweep(ph, M, b);
            s++;
            if (b == 0) begin
                exp_succ = 1;
                break;
            end
            if (ph == 2) ph = 3;
            else if (exp_iter == MI) begin
                exp_succ = 0;
                break;
            end else begin
                push_sweep(4, N, 16'($urandom));
                exp_iter++;
            end
        end
        e = '{ph: 3'd5, rd: 1'b0, ra: 4'd0, wr: 1'b0, wa: 4'd0, syn: 1'($urandom)};
        q.push_back(e);
        e.ph = 3'd0;
        q.push_back(e);
    endfunction

    task automatic run_frame(input int mode, input int abort_idx, input int rst_idx, input int busy_idx);
        logic [14:0] obs;
        logic [14:0] expv;
        build(mode);
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            obs  = {bus.o_phase, bus.o_rd_en, bus.o_rd_en ? bus.o_rd_addr : 4'd0,
                    bus.o_wr_en, bus.o_wr_en ? bus.o_wr_addr : 4'd0, bus.o_busy, bus.o_done};
            expv = {q[i].ph, q[i].rd, q[i].ra, q[i].wr, q[i].wa, q[i].ph != 3'd0, q[i].ph == 3'd5};
            total++;
            if (obs !== expv) begin
                bad++;
                if (bad < 30) $display("FAIL trace mode=%0d cyc=%0d got=%h want=%h", mode, i, obs, expv);
            end
            if (i == 0) begin
                total++;
                if ({bus.o_success, bus.o_iterations} !== 6'd0) begin
                    bad++;
                    $display("FAIL start_clear got succ=%0b iter=%0d want 0/0", bus.o_success, bus.o_iterations);
                end
            end
            if (i == q.size() - 1) begin
                total++;
                if ({bus.o_success, bus.o_iterations} !== {exp_succ, 5'(exp_iter)}) begin
                    bad++;
                    $display("FAIL result mode=%0d got succ=%0b iter=%0d want succ=%0b iter=%0d",
                             mode, bus.o_success, bus.o_iterations, exp_succ, exp_iter);
                end
            end
            if (i == rst_idx) begin
                rst = 1'b1;
                #1;
                total++;
                if ({bus.o_phase, bus.o_rd_en, bus.o_rd_addr, bus.o_wr_en, bus.o_wr_addr, bus.o_busy,
                     bus.o_done, bus.o_success, bus.o_iterations} !== 22'd0) begin
                    bad++;
                    $display("FAIL async_reset got ph=%0d rd=%0b wr=%0b busy=%0b iter=%0d want all zero",
                             bus.o_phase, bus.o_rd_en, bus.o_wr_en, bus.o_busy, bus.o_iterations);
                end
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (i == abort_idx) begin
                bus.i_abort = 1'b1;
                @(posedge clk); #1;
                bus.i_abort = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    total++;
                    if ({bus.o_phase, bus.o_rd_en, bus.o_wr_en, bus.o_busy, bus.o_done, bus.o_success} !== 8'd0) begin
                        bad++;
                        $display("FAIL abort[%0d] got ph=%0d rd=%0b wr=%0b done=%0b succ=%0b want idle zeros",
                                 j, bus.o_phase, bus.o_rd_en, bus.o_wr_en, bus.o_done, bus.o_success);
                    end
                    @(posedge clk); #1;
                end
                return;
            end
            bus.i_start  = (i == busy_idx);
            bus.i_syn_in = q[i].syn;
            if (i < q.size() - 1) begin
                @(posedge clk); #1;
            end
        end
        bus.i_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start  = 1'b0;
        bus.i_abort  = 1'b0;
        bus.i_syn_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.o_phase, bus.o_rd_en, bus.o_rd_addr, bus.o_wr_en, bus.o_wr_addr, bus.o_busy,
             bus.o_done, bus.o_success, bus.o_iterations} !== 22'd0) begin
            bad++;
            $display("FAIL reset got ph=%0d busy=%0b iter=%0d want all zero", bus.o_phase, bus.o_busy, bus.o_iterations);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_clean_frame();
        run_frame(0, -1, -1, 5);
    endtask

    task automatic test_single_check();
        run_frame(1, -1, -1, 20);
    endtask

    task automatic test_max_iter();
        run_frame(2, -1, -1, 100);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) run_frame(3, -1, -1, $urandom_range(1, 18));
    endtask

    task automatic test_abort();
        run_frame(2, (N + LAT) + 2 * (M + LAT) + 5, -1, -1);
        run_frame(0, -1, -1, -1);
    endtask

    task automatic test_reset_mid_cn();
        run_frame(2, -1, (N + LAT) + (M + LAT) + 3, -1);
        run_frame(0, -1, -1, -1);
    endtask

    task automatic test_back_to_back();
        run_frame(1, -1, -1, -1);
        run_frame(0, -1, -1, -1);
        run_frame(3, -1, -1, 3);
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_single_check();
        test_max_iter();
        test_random();
        test_abort();
        test_reset_mid_cn();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ldpc_phase_scheduler.md
LDPC_PHASE_SCHEDULER -- requirements
Module: ldpc_phase_scheduler

Interface
REQ-001 Parameter N, default 12, number of variable nodes (codeword length).
REQ-002 Parameter M, default 6, number of check nodes.
REQ-003 Parameter MAX_ITER, default 30, maximum decoding iterations.
REQ-004 Parameter LAT, default 2, cycles from read issue to write-back (BRAM read plus datapath register), range 1..4.
REQ-005 Parameters LOG2N, LOG2M and LOG2ITER, defaults 4, 3 and 5, index and iteration widths.
REQ-006 Port clk, input, 1, single clock; all logic on rising edge.
REQ-007 Port rst, input, 1, asynchronous active-high reset.
REQ-008 Port start, input, 1, begin decoding a frame; sampled in IDLE only.
REQ-009 Port abort, input, 1, synchronous abandon of the current frame.
REQ-010 Port syn_in, input, 1, parity of the check currently being written back; valid when wr_en=1 in SYN or CN.
REQ-011 Port phase, output, 3, current phase code.
REQ-012 Port rd_en / rd_addr, output, 1 / max(LOG2N,LOG2M), read strobe and node index to the message and neighbour BRAMs.
REQ-013 Port wr_en / wr_addr, output, 1 / max(LOG2N,LOG2M), write-back strobe and node index.
REQ-014 Port busy, output, 1, high in every state except IDLE.
REQ-015 Port done, output, 1, one-cycle pulse at frame completion.
REQ-016 Port success, output, 1, zero-syndrome result, held until the next accepted start.
REQ-017 Port iterations, output, LOG2ITER, count of completed VN passes, held until the next accepted start.

Function
REQ-018 The states SHALL be IDLE, LOAD, SYN, CN, VN and DONE.
REQ-019 Every non-IDLE/DONE phase SHALL be a sweep of K nodes, K=N for LOAD/VN and K=M for SYN/CN.
REQ-020 In each sweep, rd_en SHALL be high for cycles 0..K-1 with rd_addr=0..K-1, then low for LAT drain cycles (sweep length K+LAT).
REQ-021 wr_en/wr_addr SHALL equal rd_en/rd_addr delayed by exactly LAT cycles, with no overlap between sweeps.
REQ-022 The first read of the next sweep SHALL issue in the cycle after the last write of the current sweep.
REQ-023 IDLE with start=1 SHALL go to LOAD and clear success, iterations and the nonzero flag.
REQ-024 LOAD SHALL go to SYN.
REQ-025 In SYN and CN, any syn_in=1 sampled with wr_en=1 SHALL set the nonzero flag; the flag SHALL clear at the start of each SYN/CN sweep.
REQ-026 At the end of SYN or CN with the flag clear, the block SHALL go to DONE with success=1.
REQ-027 At the end of SYN with the flag set, the block SHALL go to CN.
REQ-028 At the end of CN with the flag set: if iterations==MAX_ITER, go to DONE with success=0; otherwise go to VN.
REQ-029 At the end of VN, iterations SHALL increment and the block SHALL go to CN.
REQ-030 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-031 start while busy=1 SHALL be ignored.
REQ-032 abort=1 in any non-IDLE state SHALL, next cycle, deassert rd_en/wr_en, go to IDLE, leave done=0 and set success=0; it has priority over sweep-end transitions.
REQ-033 The iteration counter SHALL never exceed MAX_ITER (no wrap).

Reset
REQ-034 rst=1 SHALL asynchronously force state IDLE.
REQ-035 rst=1 SHALL drive phase=0, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, busy=0, done=0, success=0 and iterations=0.
REQ-036 rst=1 SHALL clear the nonzero flag and the LAT delay line.
REQ-037 Reset mid-sweep SHALL drop pending writes.

Structure
REQ-038 Phase codes SHALL live in the shared decoder package: IDLE=0, LOAD=1, SYN=2, CN=3, VN=4, DONE=5.
REQ-039 Default N, M, MAX_ITER and LAT SHALL live in the same package.
REQ-040 The sweep counter and LAT delay line SHALL be one sub-module, sweep_counter (inputs K and go; outputs rd/wr strobes, addresses and last).

Verification
REQ-041 N=12, M=6, LAT=2; start, syn_in=0 -> LOAD 14 cycles, SYN 8 cycles, done pulse, success=1, iterations=0.
REQ-042 syn_in=1 on check 3 in SYN, all zero in the first CN -> CN then DONE, success=1, iterations=0, no VN sweep.
REQ-043 syn_in=1 on every write -> VN swept 30 times, done after the 31st CN, success=0, iterations=30.
REQ-044 wr_addr equals rd_addr delayed by 2 cycles; no overlap at sweep boundaries; start pulsed while busy is ignored.
REQ-045 abort in VN at rd_addr=5 -> IDLE next cycle, no further strobes, done=0.
REQ-046 rst asserted mid-CN -> all outputs zero immediately; a new start afterwards runs the normal sequence.
